seq_detector_moore: RTL and testbench

Parametrised Moore-type serial pattern detector: watches a 1-bit stream and asserts a registered flag whenever the last `PAT_W` accepted bits equal `PATTERN`. It generalises the fixed 4-bit detector with configurable pattern and width, a valid qualifier, selectable overlapping/non-overlapping matching, and an optional match counter. It sits after serial-input front ends and feeds frame-sync and alarm logic.

---
 rtl/seqdet_pkg.sv | 65 ++++++
 rtl/seqdet_sat_counter.sv | 18 +
 rtl/seq_detector_moore.sv | 78 +++++++
 tb/tb_seq_detector_moore.sv | 189 ++++++++++++++++++
 4 files changed

// File: rtl/seqdet_pkg.sv
// Shared types and elaboration-time helpers for the serial pattern detector:
// state-index width, KMP next-state/border functions and the default pattern.
package seqdet_pkg;

   localparam logic [3:0] DEFAULT_PATTERN = 4'b1011;
   localparam int         MAX_PAT_W       = 16;

   typedef enum logic [1:0] {
      SEQ_IDLE    = 2'd0,
      SEQ_PARTIAL = 2'd1,
      SEQ_MATCH   = 2'd2
   } seq_phase_e;

   function automatic int state_w(input int pat_w);
      return $clog2(pat_w + 1);
   endfunction

   // Pattern bit i counts from the MSB, i.e. bit 0 is the first bit received.
   function automatic logic pat_bit(input logic [MAX_PAT_W-1:0] pattern,
                                    input int pat_w, input int i);
      return pattern[pat_w-1-i];
   endfunction

   // Longest prefix of the pattern that is a suffix of (prefix k, then b).
   function automatic int seqdet_next(input logic [MAX_PAT_W-1:0] pattern,
                                      input int pat_w, input int k,
                                      input logic b);
      logic [MAX_PAT_W:0] seq;
      int                 result;
      logic               ok;
      seq    = '0;
      result = 0;
      for (int i = 0; i < k; i++) seq[i] = pat_bit(pattern, pat_w, i);
      seq[k] = b;
      for (int j = k + 1; j >= 1; j--) begin
         ok = (j <= pat_w) && (result == 0);
         for (int t = 0; t < j; t++)
            if (pat_bit(pattern, pat_w, t) != seq[k+1-j+t]) ok = 1'b0;
         if (ok) result = j;
      end
      return result;
   endfunction

   // Longest proper border: where a full match resumes when overlapping.
   function automatic int seqdet_border(input logic [MAX_PAT_W-1:0] pattern,
                                        input int pat_w);
      int   result;
      logic ok;
      result = 0;
      for (int j = pat_w - 1; j >= 1; j--) begin
         ok = (result == 0);
         for (int t = 0; t < j; t++)
            if (pattern[pat_w-1-t] != pattern[j-1-t]) ok = 1'b0;
         if (ok) result = j;
      end
      return result;
   endfunction

   function automatic seq_phase_e seqdet_phase(input int idx, input int pat_w);
      if (idx == pat_w) return SEQ_MATCH;
      if (idx == 0)     return SEQ_IDLE;
      return SEQ_PARTIAL;
   endfunction

endpackage

// File: rtl/seqdet_sat_counter.sv
// Saturating up-counter with synchronous active-low clear; holds at all-ones.
module seqdet_sat_counter #(
   parameter int COUNT_W = 8
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               inc,
   output logic [COUNT_W-1:0] count
);

   always_ff @(posedge clk) begin
      if (!reset)
         count <= '0;
      else if (inc && (count != {COUNT_W{1'b1}}))
         count <= count + 1'b1;
   end

endmodule

// File: rtl/seq_detector_moore.sv
// Moore serial pattern detector with elaboration-time KMP next-state table.
// Optional saturating match counter enabled by defining SEQDET_COUNT_EN.
module seq_detector_moore
   import seqdet_pkg::*;
#(
   parameter int             PAT_W   = 4,
   parameter logic [PAT_W-1:0] PATTERN = PAT_W'(DEFAULT_PATTERN),
   parameter bit             OVERLAP = 1'b1,
   parameter int             COUNT_W = 8
) (
   input  logic                      clk,
   input  logic                      reset,
   input  logic                      din,
   input  logic                      din_valid,
   output logic                      dout,
   output logic [state_w(PAT_W)-1:0] state_o
`ifdef SEQDET_COUNT_EN
   ,
   output logic [COUNT_W-1:0]        match_count
`endif
);

   localparam int SW       = state_w(PAT_W);
   localparam int N_IDX    = 2 ** SW;
   localparam int RESUME_K = OVERLAP ? seqdet_border(MAX_PAT_W'(PATTERN), PAT_W) : 0;

   logic [SW-1:0] nxt0 [N_IDX];
   logic [SW-1:0] nxt1 [N_IDX];
   logic [SW-1:0] state;
   logic [SW-1:0] nxt;
   seq_phase_e    phase;

   // Unreachable encodings above PAT_W fall back to S0.
   for (genvar k = 0; k < N_IDX; k++) begin : g_tbl
      localparam int KE = (k == PAT_W) ? RESUME_K : k;
      if (k <= PAT_W) begin : g_live
         localparam logic [SW-1:0] N0 = SW'(seqdet_next(MAX_PAT_W'(PATTERN), PAT_W, KE, 1'b0));
         localparam logic [SW-1:0] N1 = SW'(seqdet_next(MAX_PAT_W'(PATTERN), PAT_W, KE, 1'b1));
         assign nxt0[k] = N0;
         assign nxt1[k] = N1;
      end else begin : g_dead
         assign nxt0[k] = '0;
         assign nxt1[k] = '0;
      end
   end

   always_comb begin
      nxt = din ? nxt1[state] : nxt0[state];
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         state <= '0;
         phase <= SEQ_IDLE;
      end else if (din_valid) begin
         state <= nxt;
         phase <= seqdet_phase(int'(nxt), PAT_W);
      end
   end

   assign dout    = (phase == SEQ_MATCH);
   assign state_o = state;

`ifdef SEQDET_COUNT_EN
   logic inc;
   assign inc = din_valid && (nxt == SW'(PAT_W));

   seqdet_sat_counter #(
      .COUNT_W (COUNT_W)
   ) u_counter (
      .clk   (clk),
      .reset (reset),
      .inc   (inc),
      .count (match_count)
   );
`endif

endmodule

// File: tb/tb_seq_detector_moore.sv
// Directed bench for seq_detector_moore: three instances share one stream
// (1011 overlapping, 1011 non-overlapping, 111 overlapping with 2-bit counter).
module tb_seq_detector_moore;

   logic clk = 1'b0;
   logic reset = 1'b0;
   logic din = 1'b0;
   logic din_valid = 1'b0;

   logic       dout_a, dout_b, dout_c;
   logic [2:0] state_a, state_b;
   logic [1:0] state_c;
`ifdef SEQDET_COUNT_EN
   logic [7:0] count_a, count_b;
   logic [1:0] count_c;
`endif

   int n_checks = 0;
   int n_pass   = 0;

   always #5 clk = ~clk;

   seq_detector_moore #(.PAT_W(4), .PATTERN(4'b1011), .OVERLAP(1'b1), .COUNT_W(8)) u_a (
      .clk(clk), .reset(reset), .din(din), .din_valid(din_valid),
      .dout(dout_a), .state_o(state_a)
`ifdef SEQDET_COUNT_EN
      , .match_count(count_a)
`endif
   );

   seq_detector_moore #(.PAT_W(4), .PATTERN(4'b1011), .OVERLAP(1'b0), .COUNT_W(8)) u_b (
      .clk(clk), .reset(reset), .din(din), .din_valid(din_valid),
      .dout(dout_b), .state_o(state_b)
`ifdef SEQDET_COUNT_EN
      , .match_count(count_b)
`endif
   );

   seq_detector_moore #(.PAT_W(3), .PATTERN(3'b111), .OVERLAP(1'b1), .COUNT_W(2)) u_c (
      .clk(clk), .reset(reset), .din(din), .din_valid(din_valid),
      .dout(dout_c), .state_o(state_c)
`ifdef SEQDET_COUNT_EN
      , .match_count(count_c)
`endif
   );

   task automatic check(input string tag, input int obs, input int exp);
      n_checks++;
      if (obs == exp) n_pass++;
      else $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
   endtask

   // One edge with the given inputs; outputs are sampled 1 time unit after it.
   task automatic step(input logic rst_n, input logic b, input logic v);
      @(negedge clk);
      reset     = rst_n;
      din       = b;
      din_valid = v;
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      step(1'b0, 1'b0, 1'b0);
      step(1'b0, 1'b0, 1'b0);
   endtask

   task automatic check_all(input string tag, input int sa, input int sb, input int sc,
                            input int da, input int db, input int dc);
      check({tag, " state_a"}, int'(state_a), sa);
      check({tag, " state_b"}, int'(state_b), sb);
      check({tag, " state_c"}, int'(state_c), sc);
      check({tag, " dout_a"},  int'(dout_a),  da);
      check({tag, " dout_b"},  int'(dout_b),  db);
      check({tag, " dout_c"},  int'(dout_c),  dc);
   endtask

   // Stimulus rows: {din, din_valid} and expected state/dout per instance.
   typedef struct {
      logic b;
      logic v;
      int   sa, sb, sc;
      int   da, db, dc;
   } vec_t;

   vec_t t2 [7] = '{
      '{1'b1, 1'b1, 1, 1, 1, 0, 0, 0},
      '{1'b0, 1'b1, 2, 2, 0, 0, 0, 0},
      '{1'b1, 1'b1, 3, 3, 1, 0, 0, 0},
      '{1'b1, 1'b1, 4, 4, 2, 1, 1, 0},
      '{1'b0, 1'b1, 2, 0, 0, 0, 0, 0},
      '{1'b1, 1'b1, 3, 1, 1, 0, 0, 0},
      '{1'b1, 1'b1, 4, 1, 2, 1, 0, 0}
   };

   vec_t t3 [10] = '{
      '{1'b1, 1'b1, 1, 1, 1, 0, 0, 0},
      '{1'b0, 1'b1, 2, 2, 0, 0, 0, 0},
      '{1'b1, 1'b1, 3, 3, 1, 0, 0, 0},
      '{1'b0, 1'b0, 3, 3, 1, 0, 0, 0},
      '{1'b0, 1'b0, 3, 3, 1, 0, 0, 0},
      '{1'b0, 1'b0, 3, 3, 1, 0, 0, 0},
      '{1'b1, 1'b1, 4, 4, 2, 1, 1, 0},
      '{1'b1, 1'b0, 4, 4, 2, 1, 1, 0},
      '{1'b0, 1'b0, 4, 4, 2, 1, 1, 0},
      '{1'b0, 1'b1, 2, 0, 0, 0, 0, 0}
   };

   initial begin
      // Reset state
      do_reset();
      check_all("reset", 0, 0, 0, 0, 0, 0);
`ifdef SEQDET_COUNT_EN
      check("reset count_a", int'(count_a), 0);
      check("reset count_c", int'(count_c), 0);
`endif

      // Basic match then one more bit: single-cycle pulse
      step(1'b1, 1'b1, 1'b1);
      step(1'b1, 1'b0, 1'b1);
      step(1'b1, 1'b1, 1'b1);
      step(1'b1, 1'b1, 1'b1);
      check_all("basic bit4", 4, 4, 2, 1, 1, 0);
`ifdef SEQDET_COUNT_EN
      check("basic count_a", int'(count_a), 1);
`endif
      step(1'b1, 1'b0, 1'b1);
      check_all("basic bit5", 2, 0, 0, 0, 0, 0);

      // Overlap on/off
      do_reset();
      for (int i = 0; i < 7; i++) begin
         step(1'b1, t2[i].b, t2[i].v);
         check_all($sformatf("ovl bit%0d", i + 1), t2[i].sa, t2[i].sb, t2[i].sc,
                   t2[i].da, t2[i].db, t2[i].dc);
      end
`ifdef SEQDET_COUNT_EN
      check("ovl count_a", int'(count_a), 2);
      check("ovl count_b", int'(count_b), 1);
`endif

      // Valid gating, including holding in the match state
      do_reset();
      for (int i = 0; i < 10; i++) begin
         step(1'b1, t3[i].b, t3[i].v);
         check_all($sformatf("gate cyc%0d", i + 1), t3[i].sa, t3[i].sb, t3[i].sc,
                   t3[i].da, t3[i].db, t3[i].dc);
      end
`ifdef SEQDET_COUNT_EN
      check("gate count_a", int'(count_a), 1);
`endif

      // Reset mid-sequence with a valid bit present at the reset edge
      do_reset();
      step(1'b1, 1'b1, 1'b1);
      step(1'b1, 1'b0, 1'b1);
      step(1'b1, 1'b1, 1'b1);
      step(1'b1, 1'b1, 1'b1);
      step(1'b1, 1'b0, 1'b1);
      step(1'b1, 1'b1, 1'b1);
      check_all("mid pre", 3, 1, 1, 0, 0, 0);
`ifdef SEQDET_COUNT_EN
      check("mid pre count_a", int'(count_a), 1);
`endif
      step(1'b0, 1'b1, 1'b1);
      check_all("mid rst", 0, 0, 0, 0, 0, 0);
`ifdef SEQDET_COUNT_EN
      check("mid rst count_a", int'(count_a), 0);
`endif
      step(1'b1, 1'b1, 1'b1);
      check_all("mid post", 1, 1, 1, 0, 0, 0);

      // Eight consecutive ones: border case and counter saturation on u_c
      do_reset();
      for (int i = 0; i < 8; i++) begin
         step(1'b1, 1'b1, 1'b1);
         check_all($sformatf("ones bit%0d", i + 1), 1, 1, (i < 2) ? i + 1 : 3,
                   0, 0, (i >= 2) ? 1 : 0);
`ifdef SEQDET_COUNT_EN
         check($sformatf("ones count_c bit%0d", i + 1), int'(count_c),
               (i < 2) ? 0 : ((i - 1 > 3) ? 3 : i - 1));
`endif
      end

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
